// File: rtl/phv_seg_fifo_pkg.sv
// Shared PHV pipeline constants for the deparser-side PHV buffer.
package rmt_pkg;
  localparam int unsigned PHV_WIDTH_DEF    = 1024;
  localparam int unsigned SEG_WIDTH_DEF    = 512;
  localparam int unsigned PHV_SEG_NUM      = PHV_WIDTH_DEF / SEG_WIDTH_DEF;
  localparam int unsigned DEPTH_DEF        = 32;
  localparam int unsigned AFULL_MARGIN_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF    = 32;
  localparam int unsigned PTR_W_DEF        = $clog2(DEPTH_DEF);
  localparam int unsigned COUNT_W_DEF      = $clog2(DEPTH_DEF) + 1;
endpackage

// File: rtl/phv_seg_fifo_if.sv
// PHV buffer bus: write side from the last stage, read side to the deparser.
interface phv_seg_fifo_if
  import rmt_pkg::*;
#(
  parameter int unsigned PHV_WIDTH = PHV_WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 clear;
  logic [PHV_WIDTH-1:0] wr_phv;
  logic                 wr_valid;
  logic                 nearly_full;
  logic                 full;
  logic [PHV_WIDTH-1:0] rd_phv;
  logic                 empty;
  logic                 rd_en;
  logic [CW-1:0]        count;
  logic [CW-1:0]        max_count;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic [CNT_WIDTH-1:0] underflow_cnt;

  modport master (
    output clear, wr_phv, wr_valid, rd_en,
    input  nearly_full, full, rd_phv, empty, count, max_count, drop_cnt, underflow_cnt
  );

  modport slave (
    input  clear, wr_phv, wr_valid, rd_en,
    output nearly_full, full, rd_phv, empty, count, max_count, drop_cnt, underflow_cnt
  );
endinterface

// File: rtl/phv_seg_fifo_bank.sv
// One segment column of the PHV buffer: simple dual-port RAM with registered
// read of the next head address, giving first-word-fall-through output.
module phv_seg_bank
  import rmt_pkg::*;
#(
  parameter int unsigned SEG_WIDTH = SEG_WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 wr_en_i,
  input  logic [PTR_W-1:0]     wr_addr_i,
  input  logic [SEG_WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0]     rd_addr_i,
  output logic [SEG_WIDTH-1:0] rd_data_o
);
  logic [SEG_WIDTH-1:0] mem [DEPTH];
  logic [SEG_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // A write landing on the next head address only happens when the buffer is
  // otherwise empty, so forwarding the write data is the correct new head.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) dout_q <= '0;
    else if (wr_en_i && (wr_addr_i == rd_addr_i)) dout_q <= wr_data_i;
    else dout_q <= mem[rd_addr_i];
  end

  assign rd_data_o = dout_q;
endmodule

// File: rtl/phv_seg_fifo.sv
// Segmented PHV buffer: shared pointers over PHV_WIDTH/SEG_WIDTH banks, with
// nearly-full margin, flush, occupancy, watermark and drop/underflow counters.
module phv_seg_fifo
  import rmt_pkg::*;
#(
  parameter int unsigned PHV_WIDTH    = PHV_WIDTH_DEF,
  parameter int unsigned SEG_WIDTH    = SEG_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned AFULL_MARGIN = AFULL_MARGIN_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input logic           clk,
  input logic           areset,
  phv_seg_fifo_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CW      = PTR_W + 1;
  localparam int unsigned SEG_NUM = PHV_WIDTH / SEG_WIDTH;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d, max_q, max_d;
  logic                 nf_q, nf_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d, under_q, under_d;
  logic                 wr_acc, rd_acc, is_empty, is_full;
  logic [PHV_WIDTH-1:0] rd_phv;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    rd_acc   = bus.rd_en && !is_empty && !bus.clear;
    wr_acc   = bus.wr_valid && !bus.clear && (!is_full || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    under_d  = under_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_valid && !wr_acc && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
      if (bus.rd_en && is_empty && (under_q != '1)) under_d = under_q + CNT_WIDTH'(1);
    end
    // Flag derived from next-state count so it changes on the same edge as count.
    nf_d  = (CW'(DEPTH) - count_d) <= CW'(AFULL_MARGIN);
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      nf_q     <= 1'b0;
      drop_q   <= '0;
      under_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      nf_q     <= nf_d;
      drop_q   <= drop_d;
      under_q  <= under_d;
    end
  end

  for (genvar g = 0; g < SEG_NUM; g++) begin : g_bank
    phv_seg_bank #(
      .SEG_WIDTH (SEG_WIDTH),
      .DEPTH     (DEPTH),
      .PTR_W     (PTR_W)
    ) u_bank (
      .clk       (clk),
      .areset    (areset),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.wr_phv[g*SEG_WIDTH +: SEG_WIDTH]),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (rd_phv[g*SEG_WIDTH +: SEG_WIDTH])
    );
  end

  assign bus.rd_phv        = rd_phv;
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.nearly_full   = nf_q;
  assign bus.count         = count_q;
  assign bus.max_count     = max_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.underflow_cnt = under_q;
endmodule

// File: tb/tb_phv_seg_fifo.sv
// Scoreboard bench for phv_seg_fifo: directed vectors, negedge pop monitor.
module tb_phv_seg_fifo;
  localparam int unsigned PW = 1024;
  localparam int unsigned SW = 512;
  localparam int unsigned D  = 32;
  localparam int unsigned M  = 4;
  localparam int unsigned CN = 32;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  phv_seg_fifo_if #(.PHV_WIDTH(PW), .DEPTH(D), .CNT_WIDTH(CN)) bus ();

  phv_seg_fifo #(
    .PHV_WIDTH    (PW),
    .SEG_WIDTH    (SW),
    .DEPTH        (D),
    .AFULL_MARGIN (M),
    .CNT_WIDTH    (CN)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  logic [PW-1:0] sb [$];
  int checks = 0;
  int failures = 0;
  int mcnt = 0, mmax = 0, mdrop = 0, munder = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual_hi=%h actual_lo=%h required_hi=%h required_lo=%h",
               name, act[PW-1:PW-64], act[63:0], exp[PW-1:PW-64], exp[63:0]);
    end
  endtask

  // Monitor: every accepted pop must present the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!areset && bus.rd_en === 1'b1 && bus.clear === 1'b0 && bus.empty === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=head_present required=no_entry");
      end else begin
        chk("rd_phv", bus.rd_phv, sb.pop_front());
      end
    end
  end

  task automatic chk_flags();
    chk("count", PW'(bus.count), PW'(mcnt));
    chk("empty", PW'(bus.empty), PW'(mcnt == 0));
    chk("full", PW'(bus.full), PW'(mcnt == int'(D)));
    chk("nearly_full", PW'(bus.nearly_full), PW'((int'(D) - mcnt) <= int'(M)));
    chk("max_count", PW'(bus.max_count), PW'(mmax));
    chk("drop_cnt", PW'(bus.drop_cnt), PW'(mdrop));
    chk("underflow_cnt", PW'(bus.underflow_cnt), PW'(munder));
  endtask

  task automatic step(input bit wv, input logic [PW-1:0] d, input bit re, input bit clr);
    bit racc, wacc;
    bus.wr_valid = wv;
    bus.wr_phv   = d;
    bus.rd_en    = re;
    bus.clear    = clr;
    racc = re && (mcnt > 0) && !clr;
    wacc = wv && !clr && ((mcnt < int'(D)) || racc);
    if (clr) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (wacc) sb.push_back(d);
      if (wv && !wacc) mdrop++;
      if (re && mcnt == 0) munder++;
      mcnt = mcnt + int'(wacc) - int'(racc);
      if (mcnt > mmax) mmax = mcnt;
    end
    @(posedge clk);
    #1;
    chk_flags();
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_phv   = '0;
    bus.rd_en    = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic reset_model();
    sb.delete();
    mcnt = 0; mmax = 0; mdrop = 0; munder = 0;
  endtask

  initial begin
    logic [PW-1:0] a_phv, b_phv, d;
    logic [SW-1:0] h;
    int idx;
    bit wv, re;

    idle_inputs();
    a_phv = {(PW/8){8'hA5}};
    b_phv = {(PW/8){8'h3C}};
    #12;
    chk_flags();
    chk("reset_rd_phv", bus.rd_phv, '0);
    @(posedge clk); #1;
    areset = 1'b0;

    // Single write then single pop
    step(1'b1, a_phv, 1'b0, 1'b0);
    chk("head_A", bus.rd_phv, a_phv);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, watching nearly_full, then one dropped write
    for (int i = 0; i < 32; i++) step(1'b1, PW'(i), 1'b0, 1'b0);
    step(1'b1, PW'(999), 1'b0, 1'b0);

    // Full with simultaneous read/write across wrap, then drain
    for (int i = 32; i < 42; i++) step(1'b1, PW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 40 && mcnt > 0; i++) step(1'b0, '0, 1'b1, 1'b0);

    // 100 PHVs with distinct halves and random pops
    idx = 0;
    for (int cyc = 0; cyc < 600 && (idx < 100 || mcnt > 0); cyc++) begin
      wv = (idx < 100) && (mcnt < int'(D));
      re = (idx >= 100) ? 1'b1 : 1'(($urandom_range(0, 1)));
      h  = SW'(idx);
      d  = {h, ~h};
      step(wv, d, re, 1'b0);
      if (wv) idx++;
    end
    chk("burst_complete", PW'((idx == 100) && (mcnt == 0)), PW'(1));

    // Underflow on empty, then simultaneous read+write on empty
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, b_phv, 1'b1, 1'b0);
    chk("head_B", bus.rd_phv, b_phv);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a same-cycle write
    for (int i = 0; i < 5; i++) step(1'b1, PW'(100 + i), 1'b0, 1'b0);
    step(1'b1, PW'(777), 1'b1, 1'b1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) step(1'b1, PW'(200 + i), 1'b0, 1'b0);
    idle_inputs();
    #2;
    areset = 1'b1;
    #1;
    reset_model();
    chk_flags();
    chk("areset_rd_phv", bus.rd_phv, '0);
    #3;
    areset = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    step(1'b1, a_phv, 1'b0, 1'b0);
    chk("head_after_reset", bus.rd_phv, a_phv);
    step(1'b0, '0, 1'b1, 1'b0);
    idle_inputs();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phv_seg_fifo.md
Name: phv_seg_fifo

Overview:
- Parametrised PHV buffer between the last match-action stage and the deparser.
- Replaces the fixed pair of 512-bit PHV FIFOs that share one write enable and one read enable.
- PHV_WIDTH is split into PHV_WIDTH/SEG_WIDTH segment banks that share one pointer set, so segments can never desynchronise.
- Adds a programmable nearly-full margin (absorbs stage pipeline skid), first-word-fall-through output, synchronous flush, occupancy, high-watermark and drop/underflow statistics.

Parameters:
- PHV_WIDTH, 1024: PHV width in bits. Must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 512: bank width in bits (one BRAM column group).
- DEPTH, 32: entries. Power of two, minimum 4.
- AFULL_MARGIN, 4: nearly_full asserts when free entries <= AFULL_MARGIN. Range 1..DEPTH-1.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  single clock for all logic
- areset  in  1  asynchronous reset, active-high
- clear  in  1  synchronous flush
- wr_phv  in  PHV_WIDTH  PHV from the final stage
- wr_valid  in  1  write request, one PHV per cycle
- nearly_full  out  1  backpressure to the final stage's ready input
- full  out  1  no free entries
- rd_phv  out  PHV_WIDTH  head entry (FWFT)
- empty  out  1  no entry at the head
- rd_en  in  1  pop request from the deparser
- count  out  $clog2(DEPTH)+1  current occupancy
- max_count  out  $clog2(DEPTH)+1  high watermark since reset
- drop_cnt  out  CNT_WIDTH  writes rejected because full
- underflow_cnt  out  CNT_WIDTH  rd_en asserted while empty

Behaviour:
- Reset (areset high, asynchronous):
  - All pointers, count, max_count, drop_cnt and underflow_cnt are 0.
  - empty=1, full=0, nearly_full=0, rd_phv=0.
- Write acceptance:
  - Accept when wr_valid && (!full || (rd_en && !empty)).
  - An accepted write stores all segments at wr_ptr and increments wr_ptr modulo DEPTH.
  - wr_valid while full with no pop: entry discarded, drop_cnt +1.
- Read acceptance:
  - Accept when rd_en && !empty; rd_ptr increments modulo DEPTH.
  - rd_en while empty: no state change, underflow_cnt +1.
- Latency:
  - A write into an empty FIFO is visible on rd_phv, with empty deasserted, on the cycle after the write.
  - After a pop, the next head is valid on the following cycle. Back-to-back pops give one PHV per cycle.
  - rd_phv holds its value while empty=0 and rd_en=0.
- Simultaneous events:
  - Read and write both accepted: count unchanged.
  - Empty FIFO with rd_en and wr_valid: only the write is accepted, and underflow_cnt increments.
  - Full FIFO with rd_en and wr_valid: both accepted, count stays DEPTH, no drop.
- Flags:
  - count is a registered value.
  - full = (count==DEPTH).
  - nearly_full = (DEPTH-count <= AFULL_MARGIN), registered from next-state count so it tracks count with zero lag.
- max_count: updated whenever next count exceeds it; cleared only by areset.
- Counters:
  - drop_cnt and underflow_cnt saturate at all-ones; they do not wrap.
  - Cleared only by areset.
- Flush:
  - clear forces pointers and count to 0 and empty to 1 on the next edge.
  - Statistics are kept.
  - clear takes priority over the same-cycle read and write; both are ignored and not counted.
- Pointer width: $clog2(DEPTH) bits with natural wrap. Occupancy comes from the count register, not pointer comparison.
- areset mid-operation: all stored PHVs are lost. Outputs take reset values immediately, asynchronously.

Decomposition:
- Shared package rmt_pkg holds the constants:
  - PHV_WIDTH_DEF = 1024
  - SEG_WIDTH_DEF = 512
  - PHV_SEG_NUM = PHV_WIDTH/SEG_WIDTH
  - $clog2-derived pointer and count widths
- One sub-module, phv_seg_bank:
  - A DEPTH x SEG_WIDTH simple dual-port RAM with registered read and FWFT prefetch.
  - Instantiated PHV_SEG_NUM times by generate, all driven by the common wr_en, wr_ptr and rd_ptr.
- Control, flags and statistics stay in phv_seg_fifo.

Test Plan:
- Reset, then write PHV A=0xA5..A5 (1024 bits) on one cycle → next cycle empty=0, rd_phv=A, count=1. Pop → empty=1 the cycle after, count=0.
- DEPTH=32, AFULL_MARGIN=4: 28 consecutive writes → nearly_full rises in the same cycle count reaches 28. After 32 writes full=1. 33rd write → drop_cnt=1, count=32.
- Full FIFO, rd_en and wr_valid together for 10 cycles → count stays 32, drop_cnt unchanged, FIFO order preserved across wrap-around (values 0..41).
- Write distinct upper and lower 512-bit halves (upper=index, lower=~index) for 100 PHVs with random rd_en → every read pairs matching halves, in order. max_count equals the peak reference-model occupancy.
- rd_en while empty for 3 cycles → underflow_cnt=3, no state change. Empty FIFO with rd_en+wr_valid → count=1, underflow_cnt=4.
- 5 entries stored, clear with wr_valid in the same cycle → count=0, empty=1, drop_cnt unchanged. areset pulse mid-burst → all outputs return to reset values asynchronously.
